// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: interrupt controller beside the RAT MCU.
// Rising edges on SRC are synchronized and latched as pending. The lowest
// eligible (pending and unmasked) index is presented to the MCU as a
// fixed-width INTERRUPT pulse. Software reads the ID/status and mask bytes
// through INT_DATA, writes the mask, and acknowledges via an OUT to ACK_PORT.
module rat_int_ctrl #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] ID_PORT   = 8'h30,
   parameter logic [7:0] MASK_PORT = 8'h31,
   parameter logic [7:0] ACK_PORT  = 8'h32,
   parameter int         PULSE_CYC = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_SRC-1:0] SRC,
   input  logic [7:0]       PORT_ID,
   input  logic [7:0]       OUT_PORT,
   input  logic             IO_STRB,
   output logic [7:0]       INT_DATA,
   output logic             INTERRUPT
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ASSERT   = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [N_SRC-1:0] sync1, sync2, sync3;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pending, mask, elig, clr;
   logic             ovf;
   logic [2:0]       id, id_nxt, low_idx;
   logic [3:0]       cnt, cnt_nxt;
   logic             int_nxt;
   logic             ack, mask_wr;
   logic [7:0]       mask_ext;

   // Ack is only meaningful while an interrupt is outstanding.
   assign ack     = IO_STRB && (PORT_ID == ACK_PORT) && (state != S_IDLE);
   assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
   assign elig    = pending & mask;

   // Two-flop synchronizer, then a registered one-cycle rising-edge strobe.
   // All zero out of reset, so a source already high on release is one edge.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (RESET) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
         rise  <= '0;
      end else begin
         sync1 <= SRC;
         sync2 <= sync1;
         sync3 <= sync2;
         rise  <= sync2 & ~sync3;
      end
   end

   // Fixed priority: the lowest eligible index wins; one-hot clear on ack.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      low_idx = '0;
      clr     = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) low_idx = 3'(i);
      end
      for (int i = 0; i < N_SRC; i++) begin
         clr[i] = ack && (id == 3'(i));
      end
   end

   // Pending/overflow/mask bookkeeping; a new edge beats a same-cycle clear.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending <= '0;
         ovf     <= 1'b0;
         mask    <= '0;
      end else begin
         pending <= (pending & ~clr) | rise;
         if (ack) begin
            ovf <= 1'b0;
         end else if (|(rise & pending)) begin
            ovf <= 1'b1;
         end
         if (mask_wr) mask <= OUT_PORT[N_SRC-1:0];
      end
   end

   // Next-state logic: pick a source in IDLE, time the pulse, await the ack.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      id_nxt    = id;
      int_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (|elig) begin
               state_nxt = S_ASSERT;
               id_nxt    = low_idx;
               cnt_nxt   = 4'(PULSE_CYC - 1);
               int_nxt   = 1'b1;
            end
         end
         S_ASSERT: begin
            if (ack) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = S_WAIT_ACK;
            end else begin
               cnt_nxt = cnt - 4'd1;
               int_nxt = 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (ack) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; INTERRUPT is a flop so the MCU sees a clean level.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         cnt       <= '0;
         id        <= '0;
         INTERRUPT <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         id        <= id_nxt;
         INTERRUPT <= int_nxt;
      end
   end

   // IN-port read data, decoded directly from PORT_ID.
   always_comb begin
      mask_ext                = '0;
      mask_ext[N_SRC-1:0]     = mask;
      INT_DATA                = 8'h00;
      if (PORT_ID == ID_PORT) begin
         INT_DATA = {(state != S_IDLE), ovf, 3'b000, id};
      end else if (PORT_ID == MASK_PORT) begin
         INT_DATA = mask_ext;
      end
   end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Bench for rat_int_ctrl: directed scenarios plus a randomized run, all
// checked against a transaction-level model of pending events and pulses.
module tb_rat_int_ctrl;

   localparam int         N_SRC     = 4;
   localparam int         PULSE_CYC = 4;
   localparam logic [7:0] ID_PORT   = 8'h30;
   localparam logic [7:0] MASK_PORT = 8'h31;
   localparam logic [7:0] ACK_PORT  = 8'h32;

   logic             CLK = 1'b0;
   logic             RESET;
   logic [N_SRC-1:0] SRC;
   logic [7:0]       PORT_ID, OUT_PORT;
   logic             IO_STRB;
   logic [7:0]       INT_DATA;
   logic             INTERRUPT;

   int errors = 0;
   int checks = 0;

   rat_int_ctrl #(
      .N_SRC(N_SRC), .ID_PORT(ID_PORT), .MASK_PORT(MASK_PORT),
      .ACK_PORT(ACK_PORT), .PULSE_CYC(PULSE_CYC)
   ) dut (
      .CLK(CLK), .RESET(RESET), .SRC(SRC), .PORT_ID(PORT_ID),
      .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INT_DATA(INT_DATA),
      .INTERRUPT(INTERRUPT)
   );

   always #5 CLK = ~CLK;

   // Reference model: events become pending three edges after the edge that
   // first sees the source high; a busy interrupt has a count of high cycles
   // still to go and then waits for an ack.
   typedef struct { int at; int b; } ev_t;
   ev_t              evq[$];
   int               cyc = 0;
   bit [N_SRC-1:0]   src_prev, m_pend, m_mask;
   bit               m_ovf, m_busy;
   int               m_left;
   logic [2:0]       m_id;

   function automatic bit exp_int();
      return m_busy && (m_left > 0);
   endfunction

   function automatic logic [7:0] exp_data(logic [7:0] pid);
      if (pid == ID_PORT)   return {m_busy, m_ovf, 3'b000, m_id};
      if (pid == MASK_PORT) return 8'(m_mask);
      return 8'h00;
   endfunction

   task automatic model_update();
      bit [N_SRC-1:0] rise, elig;
      bit             ack, hit;
      cyc++;
      if (RESET) begin
         m_pend = '0; m_mask = '0; m_ovf = 0; m_busy = 0; m_left = 0;
         m_id = '0; src_prev = '0; evq.delete();
         return;
      end
      rise = '0;
      for (int k = evq.size() - 1; k >= 0; k--) begin
         if (evq[k].at == cyc) begin
            rise[evq[k].b] = 1'b1;
            evq.delete(k);
         end
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (SRC[i] && !src_prev[i]) evq.push_back('{cyc + 3, i});
      end
      src_prev = SRC;
      ack  = IO_STRB && (PORT_ID == ACK_PORT) && m_busy;
      elig = m_pend & m_mask;
      hit  = |(rise & m_pend);
      if (!m_busy) begin
         for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) m_id = 3'(i);
         end
         if (elig != 0) begin
            m_busy = 1;
            m_left = PULSE_CYC;
         end
      end else if (ack) begin
         m_busy = 0;
         m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
      end
      if (ack) begin
         m_pend[m_id] = 1'b0;
         m_ovf = 0;
      end else if (hit) begin
         m_ovf = 1;
      end
      m_pend = m_pend | rise;
      if (IO_STRB && (PORT_ID == MASK_PORT)) m_mask = OUT_PORT[N_SRC-1:0];
   endtask

   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic io_strobe(input logic [7:0] addr, input logic [7:0] data);
      IO_STRB  = 1'b1;
      PORT_ID  = addr;
      OUT_PORT = data;
      step();
      IO_STRB  = 1'b0;
      PORT_ID  = ID_PORT;
      #1;
   endtask

   task automatic wait_int_high(input int budget, output bit ok);
      ok = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         step();
         ok = (INTERRUPT === 1'b1);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; SRC = '0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
      repeat (3) step();
      checks++;
      if (INTERRUPT !== 1'b0) begin
         errors++; $display("FAIL reset_int: got %b expected 0", INTERRUPT);
      end
      RESET = 1'b0;
      PORT_ID = ID_PORT; #1;
      checks++;
      if (INT_DATA !== 8'h00) begin
         errors++; $display("FAIL reset_id: got %h expected 00", INT_DATA);
      end
      PORT_ID = MASK_PORT; #1;
      checks++;
      if (INT_DATA !== 8'h00) begin
         errors++; $display("FAIL reset_mask: got %h expected 00", INT_DATA);
      end
      PORT_ID = 8'h55; #1;
      checks++;
      if (INT_DATA !== 8'h00) begin
         errors++; $display("FAIL reset_other: got %h expected 00", INT_DATA);
      end
   endtask

   task automatic test_mask_gate();
      int hi = 0;
      SRC[2] = 1'b1;
      PORT_ID = ID_PORT;
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (INTERRUPT !== 1'b0 || INT_DATA !== 8'h00) begin
            errors++;
            $display("FAIL masked_quiet: int=%b data=%h expected 0/00", INTERRUPT, INT_DATA);
         end
      end
      io_strobe(MASK_PORT, 8'h04);
      checks++;
      if (INTERRUPT !== 1'b0) begin
         errors++; $display("FAIL unmask_edge: got %b expected 0", INTERRUPT);
      end
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (INTERRUPT !== exp_int()) begin
            errors++; $display("FAIL unmask_pulse c%0d: got %b expected %b", c, INTERRUPT, exp_int());
         end
         if (INTERRUPT === 1'b1) begin
            hi++;
            checks++;
            if (INT_DATA !== 8'h82) begin
               errors++; $display("FAIL active_id: got %h expected 82", INT_DATA);
            end
         end
      end
      checks++;
      if (hi != PULSE_CYC) begin
         errors++; $display("FAIL pulse_width: got %0d expected %0d", hi, PULSE_CYC);
      end
      io_strobe(ACK_PORT, 8'hFF);
      SRC = '0;
      checks++;
      if (INTERRUPT !== 1'b0 || INT_DATA !== 8'h02) begin
         errors++; $display("FAIL ack_idle: int=%b data=%h expected 0/02", INTERRUPT, INT_DATA);
      end
   endtask

   task automatic test_priority();
      bit ok;
      io_strobe(MASK_PORT, 8'h0F);
      SRC = 4'b1010;
      wait_int_high(10, ok);
      checks++;
      if (!ok || INT_DATA !== 8'h81) begin
         errors++; $display("FAIL prio_first: int=%b data=%h expected 1/81", INTERRUPT, INT_DATA);
      end
      repeat (PULSE_CYC) step();
      io_strobe(ACK_PORT, 8'h00);
      checks++;
      if (INTERRUPT !== 1'b0) begin
         errors++; $display("FAIL prio_gap: got %b expected 0", INTERRUPT);
      end
      step();
      checks++;
      if (INTERRUPT !== 1'b1 || INT_DATA !== 8'h83) begin
         errors++; $display("FAIL prio_second: int=%b data=%h expected 1/83", INTERRUPT, INT_DATA);
      end
      repeat (PULSE_CYC + 1) step();
      io_strobe(ACK_PORT, 8'h00);
      SRC = '0;
      repeat (4) step();
      checks++;
      if (INTERRUPT !== 1'b0 || INT_DATA !== 8'h03) begin
         errors++; $display("FAIL prio_done: int=%b data=%h expected 0/03", INTERRUPT, INT_DATA);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      SRC[0] = 1'b1; step();
      SRC[0] = 1'b0; step();
      SRC[0] = 1'b1; step();
      SRC[0] = 1'b0;
      wait_int_high(10, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL ovf_pulse: got %b expected 1", INTERRUPT);
      end
      repeat (PULSE_CYC + 1) step();
      checks++;
      if (INT_DATA !== 8'hC0) begin
         errors++; $display("FAIL ovf_status: got %h expected c0", INT_DATA);
      end
      io_strobe(ACK_PORT, 8'h00);
      checks++;
      if (INT_DATA !== 8'h00) begin
         errors++; $display("FAIL ovf_cleared: got %h expected 00", INT_DATA);
      end
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (INTERRUPT !== 1'b0) begin
            errors++; $display("FAIL ovf_no_repulse c%0d: got %b expected 0", c, INTERRUPT);
         end
      end
   endtask

   task automatic test_early_ack();
      bit ok;
      SRC[2] = 1'b1;
      wait_int_high(10, ok);
      step();
      checks++;
      if (!ok || INTERRUPT !== 1'b1) begin
         errors++; $display("FAIL early_second_cycle: got %b expected 1", INTERRUPT);
      end
      io_strobe(ACK_PORT, 8'h00);
      checks++;
      if (INTERRUPT !== 1'b0 || INT_DATA !== 8'h02) begin
         errors++; $display("FAIL early_ack: int=%b data=%h expected 0/02", INTERRUPT, INT_DATA);
      end
      for (int c = 0; c < 6; c++) begin
         step();
         checks++;
         if (INTERRUPT !== 1'b0) begin
            errors++; $display("FAIL early_cleared c%0d: got %b expected 0", c, INTERRUPT);
         end
      end
      SRC = '0;
      step();
   endtask

   task automatic test_ack_collision();
      bit ok;
      int hi;
      SRC[1] = 1'b1;
      wait_int_high(10, ok);
      SRC[1] = 1'b0; step();
      SRC[1] = 1'b1; step();
      step();
      step();
      io_strobe(ACK_PORT, 8'h00);
      checks++;
      if (INTERRUPT !== 1'b0) begin
         errors++; $display("FAIL coll_ack: got %b expected 0", INTERRUPT);
      end
      step();
      checks++;
      if (INTERRUPT !== 1'b1 || INT_DATA !== 8'h81) begin
         errors++; $display("FAIL coll_repulse: int=%b data=%h expected 1/81", INTERRUPT, INT_DATA);
      end
      hi = 1;
      io_strobe(MASK_PORT, 8'h00);
      if (INTERRUPT === 1'b1) hi++;
      for (int c = 0; c < 6; c++) begin
         step();
         if (INTERRUPT === 1'b1) hi++;
      end
      checks++;
      if (hi != PULSE_CYC || INT_DATA !== 8'h81) begin
         errors++; $display("FAIL coll_mask_keep: width=%0d data=%h expected %0d/81", hi, INT_DATA, PULSE_CYC);
      end
      io_strobe(ACK_PORT, 8'h00);
      SRC = '0;
      step();
   endtask

   task automatic test_reset_mid();
      bit ok;
      io_strobe(MASK_PORT, 8'h0F);
      SRC = 4'b0101;
      wait_int_high(10, ok);
      step();
      RESET = 1'b1;
      step();
      checks++;
      if (INTERRUPT !== 1'b0) begin
         errors++; $display("FAIL rst_mid_int: got %b expected 0", INTERRUPT);
      end
      RESET = 1'b0;
      PORT_ID = ID_PORT; #1;
      checks++;
      if (INT_DATA !== 8'h00) begin
         errors++; $display("FAIL rst_mid_id: got %h expected 00", INT_DATA);
      end
      PORT_ID = MASK_PORT; #1;
      checks++;
      if (INT_DATA !== 8'h00) begin
         errors++; $display("FAIL rst_mid_mask: got %h expected 00", INT_DATA);
      end
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (INTERRUPT !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet c%0d: got %b expected 0", c, INTERRUPT);
         end
      end
      SRC = '0;
      step();
   endtask

   task automatic test_random();
      int b;
      for (int c = 0; c < 2000; c++) begin
         RESET = ($urandom_range(199) == 0);
         if ($urandom_range(5) == 0) begin
            b = $urandom_range(N_SRC - 1);
            SRC[b] = ~SRC[b];
         end
         IO_STRB = ($urandom_range(4) == 0);
         case ($urandom_range(3))
            0:       PORT_ID = ID_PORT;
            1:       PORT_ID = MASK_PORT;
            2:       PORT_ID = ACK_PORT;
            default: PORT_ID = 8'($urandom_range(255));
         endcase
         OUT_PORT = 8'($urandom);
         step();
         checks++;
         if (INTERRUPT !== exp_int() || INT_DATA !== exp_data(PORT_ID)) begin
            errors++;
            $display("FAIL rand c%0d: int=%b data=%h expected %b/%h", c, INTERRUPT, INT_DATA,
                     exp_int(), exp_data(PORT_ID));
         end
      end
      RESET = 1'b0;
      IO_STRB = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mask_gate();
      test_priority();
      test_overflow();
      test_early_ack();
      test_ack_collision();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
